// File: rtl/unified_mem_arb_if.sv
// unified_mem_arb_if: fetch and data port bundle between a core and the shared memory arbiter
interface unified_mem_arb_if #(parameter int ADDR_W = 10);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              i_valid;
    logic [31:0]       i_rdata;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_func3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic              d_valid;
    logic [31:0]       d_rdata;
    logic              d_err;
    modport master (
        output i_req, i_addr, d_req, d_we, d_func3, d_addr, d_wdata,
        input  i_ready, i_valid, i_rdata, i_err, d_ready, d_valid, d_rdata, d_err
    );
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_func3, d_addr, d_wdata,
        output i_ready, i_valid, i_rdata, i_err, d_ready, d_valid, d_rdata, d_err
    );
endinterface

// File: rtl/unified_mem_arb.sv
// unified_mem_arb: single-ported byte memory shared by an instruction fetch port and an RV32 load/store port
module unified_mem_arb #(
    parameter int ADDR_W     = 10,
    parameter int DATA_BASE  = 512,
    parameter int STARVE_MAX = 3
) (
    input logic              clk,
    input logic              rst,
    unified_mem_arb_if.slave bus
);
    localparam int                DEPTH = 1 << ADDR_W;
    localparam int                CW    = $clog2(STARVE_MAX + 2);
    localparam logic [CW-1:0]     SMAX  = CW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(DATA_BASE);

    logic [7:0]        mem [DEPTH];
    logic [CW-1:0]     starve;
    logic              grant_d;
    logic              grant_i;
    logic [ADDR_W-1:0] eff;
    logic [7:0]        ib [4];
    logic [7:0]        db [4];
    logic [31:0]       iword;
    logic [31:0]       dword;
    logic [31:0]       load_val;
    logic              i_mis;
    logic              d_mis;
    logic              d_legal;
    logic              d_bad;
    logic [3:0]        be;

    // Data wins unless fetch has already been passed over STARVE_MAX times in a row; nothing is granted in reset
    always_comb begin
        grant_d = ~rst & bus.d_req & (~bus.i_req | (starve != SMAX));
        grant_i = ~rst & bus.i_req & ~grant_d;
    end

    assign bus.d_ready = grant_d;
    assign bus.i_ready = grant_i;

    // Byte lanes for both ports; multi-byte data accesses wrap around the top of the array
    always_comb begin
        eff = bus.d_addr + BASE;
        for (int k = 0; k < 4; k++) begin
            ib[k] = mem[bus.i_addr + ADDR_W'(k)];
            db[k] = mem[eff + ADDR_W'(k)];
        end
        iword = {ib[3], ib[2], ib[1], ib[0]};
        dword = {db[3], db[2], db[1], db[0]};
    end

    // Alignment is judged on the port address, so an unaligned DATA_BASE lets an aligned access straddle the wrap
    always_comb begin
        i_mis    = |bus.i_addr[1:0];
        d_mis    = ((bus.d_func3[1:0] == 2'b01) & bus.d_addr[0])
                 | ((bus.d_func3[1:0] == 2'b10) & |bus.d_addr[1:0]);
        d_legal  = bus.d_we ? (bus.d_func3 <= 3'd2) : !(bus.d_func3 inside {3'd3, 3'd6, 3'd7});
        d_bad    = d_mis | ~d_legal;
        load_val = bus.d_func3[1] ? dword
                 : bus.d_func3[0] ? {{16{~bus.d_func3[2] & db[1][7]}}, db[1], db[0]}
                 : {{24{~bus.d_func3[2] & db[0][7]}}, db[0]};
        be       = (~grant_d | ~bus.d_we | d_bad) ? 4'h0
                 : bus.d_func3[1] ? 4'hF
                 : bus.d_func3[0] ? 4'h3 : 4'h1;
    end

    // Contents are never reset; stores land at the accepting edge so the next access sees them
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (be[k]) mem[eff + ADDR_W'(k)] <= bus.d_wdata[8*k +: 8];
    end

    // Starve counter and registered responses; rdata holds until the next response on its port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve      <= '0;
            bus.i_valid <= 1'b0;
            bus.i_err   <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_valid <= 1'b0;
            bus.d_err   <= 1'b0;
            bus.d_rdata <= '0;
        end else begin
            starve      <= (grant_i | ~bus.i_req) ? '0
                         : (grant_d & (starve != SMAX)) ? starve + 1'b1 : starve;
            bus.i_valid <= grant_i;
            bus.i_err   <= grant_i & i_mis;
            if (grant_i) bus.i_rdata <= i_mis ? '0 : iword;
            bus.d_valid <= grant_d;
            bus.d_err   <= grant_d & d_bad;
            if (grant_d) bus.d_rdata <= (d_bad | bus.d_we) ? '0 : load_val;
        end
    end
endmodule
